// File: rtl/seg_timer_pkg.sv
// Shared definitions for the seven-segment stopwatch/countdown timer:
// FSM encoding, BCD to segment decode and a counter-width helper.
package seg_timer_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Returns {g,f,e,d,c,b,a}; values above 9 blank the digit.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter, and a
// single-cycle pulse on each accepted rising level.
module seg_debounce
  import seg_timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_pulse  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      // Any sample agreeing with the accepted level restarts the run.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_pulse  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/seg_timer_mux.sv
// BCD stopwatch / countdown timer with a multiplexed seven-segment driver.
//   state   | meaning
//   IDLE    | stopped, count holds preset
//   RUN     | prescaler running, count advances on each tick
//   PAUSE   | stopped, prescaler phase held
//   EXPIRED | countdown reached zero, waits for clear
module seg_timer_mux
  import seg_timer_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int CLK_HZ          = 10_000_000,
  parameter int TICK_HZ         = 100,
  parameter int REFRESH_HZ      = 1000,
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int DP_DIGIT        = 2
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    btn_start_i,
  input  logic                    btn_clear_i,
  input  logic                    mode_down_i,
  input  logic [4*NUM_DIGITS-1:0] load_value_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   digit_en_o,
  output logic                    running_o,
  output logic                    expired_o
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int DWELL    = CLK_HZ / REFRESH_HZ;
  localparam int PW       = clog2_min1(PRESCALE);
  localparam int DW       = clog2_min1(DWELL);
  localparam int IW       = clog2_min1(NUM_DIGITS);
  localparam int CNTW     = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] IDX_DP     = IW'(DP_DIGIT);

  logic                  w_start;
  logic                  w_clear;
  logic                  r_mode_s1;
  logic                  r_mode_s2;
  logic                  w_mode_down;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNTW-1:0]       r_count;
  logic [CNTW-1:0]       w_count_nxt;
  logic [CNTW-1:0]       w_count_inc;
  logic [CNTW-1:0]       w_count_dec;
  logic [CNTW-1:0]       w_preset;
  logic                  w_count_zero;
  logic                  w_dec_zero;
  logic [PW-1:0]         r_presc;
  logic                  w_tick;
  logic                  w_expire_tick;
  logic                  r_running;
  logic                  r_expired;

  logic [DW-1:0]         r_dwell;
  logic                  w_dwell_tc;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         w_idx_nxt;
  logic [NUM_DIGITS-1:0] r_digit_en;
  logic [NUM_DIGITS-1:0] w_en_nxt;
  logic [3:0]            w_digit_sel;
  logic [7:0]            r_seg;
  logic [7:0]            w_seg_nxt;

  seg_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_btn   (btn_start_i),
    .o_pulse (w_start)
  );

  seg_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_btn   (btn_clear_i),
    .o_pulse (w_clear)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_mode_s1 <= 1'b0;
      r_mode_s2 <= 1'b0;
    end else begin
      r_mode_s1 <= mode_down_i;
      r_mode_s2 <= r_mode_s1;
    end
  end

  assign w_mode_down = r_mode_s2;

  always_comb begin
    w_preset = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_preset[4*i +: 4] = (load_value_i[4*i +: 4] > 4'd9) ? 4'd9 : load_value_i[4*i +: 4];
    end
  end

  always_comb begin
    logic carry;
    logic borrow;
    w_count_inc = r_count;
    w_count_dec = r_count;
    carry       = 1'b1;
    borrow      = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_count_inc[4*i +: 4] = 4'd0;
        end else begin
          w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_count_dec[4*i +: 4] = 4'd9;
        end else begin
          w_count_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // A down tick from zero also expires rather than wrapping to all-9s.
  assign w_count_zero  = (r_count == '0);
  assign w_dec_zero    = w_count_zero || (w_count_dec == '0);
  assign w_tick        = (r_state == ST_RUN) && (r_presc == PRESC_LAST);
  assign w_expire_tick = w_tick && w_mode_down && w_dec_zero;

  always_comb begin
    w_state_nxt = r_state;
    if (w_clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_start) w_state_nxt = (w_mode_down && w_count_zero) ? ST_EXPIRED : ST_RUN;
        ST_RUN: begin
          if (w_expire_tick)  w_state_nxt = ST_EXPIRED;
          else if (w_start)   w_state_nxt = ST_PAUSE;
        end
        ST_PAUSE: if (w_start) w_state_nxt = ST_RUN;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_clear) begin
      w_count_nxt = w_mode_down ? w_preset : '0;
    end else if (w_tick) begin
      if (w_mode_down) w_count_nxt = w_dec_zero ? '0 : w_count_dec;
      else             w_count_nxt = w_count_inc;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_expired <= (w_state_nxt == ST_EXPIRED);
      if (!w_clear && r_state == ST_RUN) begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
      end else if (w_clear || r_state != ST_PAUSE) begin
        r_presc <= '0;
      end
    end
  end

  assign w_dwell_tc = (r_dwell == DWELL_LAST);

  // The enable register starts all-zero, so the first terminal count lands on digit 0.
  always_comb begin
    w_idx_nxt = r_idx;
    w_en_nxt  = r_digit_en;
    if (w_dwell_tc) begin
      if (r_digit_en == '0 || r_idx == IDX_LAST) begin
        w_idx_nxt = '0;
        w_en_nxt  = NUM_DIGITS'(1);
      end else begin
        w_idx_nxt = r_idx + IW'(1);
        w_en_nxt  = r_digit_en << 1;
      end
    end
  end

  assign w_digit_sel = r_count[4*w_idx_nxt +: 4];

  always_comb begin
    w_seg_nxt = 8'h00;
    if (w_en_nxt != '0) begin
      w_seg_nxt = {(w_idx_nxt == IDX_DP), bcd_to_seg(w_digit_sel)};
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_dwell    <= '0;
      r_idx      <= '0;
      r_digit_en <= '0;
      r_seg      <= 8'h00;
    end else begin
      r_dwell    <= w_dwell_tc ? '0 : r_dwell + DW'(1);
      r_idx      <= w_idx_nxt;
      r_digit_en <= w_en_nxt;
      r_seg      <= w_seg_nxt;
    end
  end

  assign seg_o      = r_seg;
  assign digit_en_o = r_digit_en;
  assign running_o  = r_running;
  assign expired_o  = r_expired;

endmodule

// File: tb/tb_seg_timer_mux.sv
// Bench for seg_timer_mux: display readback through a scoreboard, a preset
// vector table, and hand-timed sequences for tick/button corner cases.
module tb_seg_timer_mux;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        btn_start  = 1'b0;
  logic        btn_clear  = 1'b0;
  logic        mode_down  = 1'b0;
  logic [15:0] load_value = 16'h0000;
  logic [7:0]  seg;
  logic [3:0]  digit_en;
  logic        running;
  logic        expired;

  int n_tests = 0;
  int n_fail  = 0;
  int run_rises = 0;
  logic running_q = 1'b0;

  always #5 clk = ~clk;

  seg_timer_mux #(
    .NUM_DIGITS      (4),
    .CLK_HZ          (1000),
    .TICK_HZ         (100),
    .REFRESH_HZ      (250),
    .DEBOUNCE_CYCLES (4),
    .DP_DIGIT        (2)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .btn_start_i  (btn_start),
    .btn_clear_i  (btn_clear),
    .mode_down_i  (mode_down),
    .load_value_i (load_value),
    .seg_o        (seg),
    .digit_en_o   (digit_en),
    .running_o    (running),
    .expired_o    (expired)
  );

  always @(posedge clk) begin
    if (running && !running_q) run_rises++;
    running_q <= running;
  end

  typedef struct {
    string       name;
    logic [15:0] disp;
    logic        run;
    logic        exp;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic        mode;
    logic [15:0] load;
    logic [15:0] disp;
  } vec_t;

  function automatic logic [3:0] seg2dig(input logic [6:0] s);
    case (s)
      7'h3F:   return 4'd0;
      7'h06:   return 4'd1;
      7'h5B:   return 4'd2;
      7'h4F:   return 4'd3;
      7'h66:   return 4'd4;
      7'h6D:   return 4'd5;
      7'h7D:   return 4'd6;
      7'h07:   return 4'd7;
      7'h7F:   return 4'd8;
      7'h6F:   return 4'd9;
      default: return 4'hE;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic sb_push(input string name, input logic [15:0] disp, input logic run, input logic exp);
    exp_t e;
    e.name = name;
    e.disp = disp;
    e.run  = run;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Reassemble the count from one full scan; also checks the decimal point.
  task automatic read_display(output logic [15:0] val);
    val = 16'hxxxx;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (digit_en == 4'(1 << d)) begin
          val[4*d +: 4] = seg2dig(seg[6:0]);
          check("dp bit", {31'd0, seg[7]}, (d == 2) ? 32'd1 : 32'd0);
        end
      end
    end
  endtask

  task automatic sb_observe();
    logic [15:0] v;
    exp_t        e;
    read_display(v);
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: display %0h seen with no expectation queued", v);
    end else begin
      e = sb_q.pop_front();
      check({e.name, " display"}, {16'd0, v}, {16'd0, e.disp});
      check({e.name, " running"}, {31'd0, running}, {31'd0, e.run});
      check({e.name, " expired"}, {31'd0, expired}, {31'd0, e.exp});
    end
  endtask

  // Called at a negedge; the press is sampled from the following posedge.
  task automatic press(input bit is_clear);
    if (is_clear) btn_clear = 1'b1;
    else          btn_start = 1'b1;
    repeat (8) @(negedge clk);
    btn_clear = 1'b0;
    btn_start = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   base;
    logic [3:0] exp_en;

    vecs[0] = '{mode: 1'b1, load: 16'h1234, disp: 16'h1234};
    vecs[1] = '{mode: 1'b1, load: 16'h9AF3, disp: 16'h9993};
    vecs[2] = '{mode: 1'b1, load: 16'h5B07, disp: 16'h5907};
    vecs[3] = '{mode: 1'b0, load: 16'h4321, disp: 16'h0000};
    vecs[4] = '{mode: 1'b1, load: 16'h0000, disp: 16'h0000};
    vecs[5] = '{mode: 1'b1, load: 16'hFFFF, disp: 16'h9999};

    #1;
    check("reset seg", {24'd0, seg}, 32'd0);
    check("reset digit_en", {28'd0, digit_en}, 32'd0);
    check("reset running", {31'd0, running}, 32'd0);
    check("reset expired", {31'd0, expired}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle scan: select moves every 4 cycles, first select at edge 4.
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      exp_en = (e < 4) ? 4'd0 : 4'(1 << (((e / 4) - 1) % 4));
      check("idle digit_en", {28'd0, digit_en}, {28'd0, exp_en});
      check("idle seg", {24'd0, seg},
            (exp_en == 4'd0) ? 32'd0 : ((exp_en == 4'd4) ? 32'hBF : 32'h3F));
    end

    foreach (vecs[i]) begin
      mode_down  = vecs[i].mode;
      load_value = vecs[i].load;
      repeat (3) @(negedge clk);
      sb_push($sformatf("preset vec%0d", i), vecs[i].disp, 1'b0, 1'b0);
      press(1'b1);
      sb_observe();
    end

    // Up count: 1000 cycles between start and pause presses, pause coincides with tick 100.
    mode_down = 1'b0;
    repeat (3) @(negedge clk);
    press(1'b1);
    sb_push("clear up", 16'h0000, 1'b0, 1'b0);
    sb_observe();
    press(1'b0);
    check("up running", {31'd0, running}, 32'd1);
    repeat (984) @(negedge clk);
    press(1'b0);
    sb_push("up 1000 cycles", 16'h0100, 1'b0, 1'b0);
    sb_observe();
    repeat (200) @(negedge clk);
    sb_push("pause hold", 16'h0100, 1'b0, 1'b0);
    sb_observe();

    // Wrap: 9998 up, two ticks before the pause lands.
    mode_down  = 1'b1;
    load_value = 16'h9998;
    repeat (3) @(negedge clk);
    press(1'b1);
    sb_push("preset 9998", 16'h9998, 1'b0, 1'b0);
    sb_observe();
    mode_down = 1'b0;
    repeat (3) @(negedge clk);
    btn_start = 1'b1;
    repeat (8) @(negedge clk);
    btn_start = 1'b0;
    repeat (17) @(negedge clk);
    btn_start = 1'b1;
    repeat (2) @(negedge clk);
    check("running after wrap", {31'd0, running}, 32'd1);
    repeat (6) @(negedge clk);
    btn_start = 1'b0;
    repeat (8) @(negedge clk);
    sb_push("wrap to 0000", 16'h0000, 1'b0, 1'b0);
    sb_observe();

    // Countdown from 3 to expiry, then start ignored, clear recovers.
    mode_down  = 1'b1;
    load_value = 16'h0003;
    repeat (3) @(negedge clk);
    press(1'b1);
    press(1'b0);
    check("down running", {31'd0, running}, 32'd1);
    repeat (40) @(negedge clk);
    sb_push("down expired", 16'h0000, 1'b0, 1'b1);
    sb_observe();
    press(1'b0);
    sb_push("start in expired", 16'h0000, 1'b0, 1'b1);
    sb_observe();
    press(1'b1);
    sb_push("clear expired", 16'h0003, 1'b0, 1'b0);
    sb_observe();

    // Start at zero in down mode expires without waiting for a tick.
    load_value = 16'h0000;
    press(1'b1);
    press(1'b0);
    check("zero start expired", {31'd0, expired}, 32'd1);
    check("zero start running", {31'd0, running}, 32'd0);

    // Bouncing start yields exactly one RUN entry.
    mode_down = 1'b0;
    repeat (3) @(negedge clk);
    press(1'b1);
    base = run_rises;
    for (int i = 0; i < 6; i++) begin
      btn_start = ~btn_start;
      repeat (2) @(negedge clk);
    end
    btn_start = 1'b1;
    repeat (20) @(negedge clk);
    btn_start = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce run entries", run_rises - base, 32'd1);
    check("bounce running", {31'd0, running}, 32'd1);
    press(1'b0);
    check("paused after bounce", {31'd0, running}, 32'd0);
    btn_start = 1'b1;
    repeat (3) @(negedge clk);
    btn_start = 1'b0;
    repeat (15) @(negedge clk);
    check("glitch ignored", {31'd0, running}, 32'd0);

    // Clear and start together from PAUSE: clear wins.
    btn_start = 1'b1;
    btn_clear = 1'b1;
    repeat (8) @(negedge clk);
    btn_start = 1'b0;
    btn_clear = 1'b0;
    repeat (8) @(negedge clk);
    sb_push("clear beats start", 16'h0000, 1'b0, 1'b0);
    sb_observe();

    // Asynchronous reset in the middle of a run.
    press(1'b0);
    repeat (25) @(negedge clk);
    check("running before reset", {31'd0, running}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid reset seg", {24'd0, seg}, 32'd0);
    check("mid reset digit_en", {28'd0, digit_en}, 32'd0);
    check("mid reset running", {31'd0, running}, 32'd0);
    check("mid reset expired", {31'd0, expired}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post reset digit_en idle", {28'd0, digit_en}, 32'd0);
    @(negedge clk);
    check("post reset first select", {28'd0, digit_en}, 32'd1);
    repeat (30) @(negedge clk);
    sb_push("after reset", 16'h0000, 1'b0, 1'b0);
    sb_observe();

    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_timer_mux.md
# seg_timer_mux

Parametrised multi-digit BCD stopwatch/countdown timer with a multiplexed seven-segment display driver. It sits in the Caravel user area behind the user-project wrapper. It is clocked from the Wishbone clock and drives segment and digit-enable pads directly. Debounced pad buttons control it: start/stop, clear, and count direction. A countdown that reaches zero raises a sticky expiry flag.

## Interface
- NUM_DIGITS, 4: BCD digits counted and scanned (2..8)
- CLK_HZ, 10_000_000: input clock frequency
- TICK_HZ, 100: count rate; prescale = CLK_HZ/TICK_HZ cycles per tick
- REFRESH_HZ, 1000: per-digit scan rate; dwell = CLK_HZ/REFRESH_HZ cycles per digit
- DEBOUNCE_CYCLES, 50_000: stable cycles required before a button edge is accepted
- DP_DIGIT, 2: digit index with decimal point lit
- wb_clk_i  in  1  sole clock
- wb_rst_ni  in  1  asynchronous, active-low reset
- btn_start_i  in  1  raw start/stop button, active-high, asynchronous
- btn_clear_i  in  1  raw clear button, active-high, asynchronous
- mode_down_i  in  1  level: 1 = count down, 0 = count up; double-flop synchronised
- load_value_i  in  4*NUM_DIGITS  BCD preset for countdown; digit 0 in the LSBs
- seg_o  out  8  {dp,g,f,e,d,c,b,a}, active-high, registered
- digit_en_o  out  NUM_DIGITS  one-hot active-high digit select, registered
- running_o  out  1  high in RUN
- expired_o  out  1  sticky countdown-reached-zero flag

## Operation
- Button path: 2-flop synchroniser, then a stability counter. A level change is accepted after DEBOUNCE_CYCLES consecutive equal samples. Only an accepted 0→1 edge produces a 1-cycle pulse.
- FSM states: IDLE, RUN, PAUSE, EXPIRED.
  - start pulse: IDLE→RUN, RUN→PAUSE, PAUSE→RUN; ignored in EXPIRED.
  - clear pulse: any state→IDLE. Count loads the preset: load_value_i if mode_down, else 0. expired_o clears.
- Preset digits greater than 9 are saturated to 9 at load.
- Prescaler runs only in RUN. In PAUSE it holds its value; in IDLE and EXPIRED it is reset to 0. Its terminal count produces a tick.
- On a tick the direction is taken from the synchronised mode_down at that cycle; changing mode mid-run therefore takes effect on the next tick.
  - Up: BCD increment with ripple carry. All-9s wraps to 0 and the timer stays in RUN.
  - Down: BCD decrement with borrow. A tick that produces 0 moves the FSM to EXPIRED and sets expired_o. The count holds at 0.
- Down mode with a count of 0 when start is pressed: IDLE→EXPIRED immediately, no tick consumed.
- Simultaneous events:
  - clear beats start.
  - clear beats a tick in the same cycle.
  - start→PAUSE and a tick in the same cycle: the tick is applied, then the FSM pauses.
- Scan: the dwell counter advances the digit index 0..NUM_DIGITS-1 and wraps. seg_o is the decoded BCD of the selected digit. Bit 7 is set only when index == DP_DIGIT.
- Scan runs in every state, including IDLE.

## Timing
- Reset values: seg_o=0, digit_en_o=0, running_o=0, expired_o=0, count=0, FSM=IDLE, all counters 0.
- The first dwell terminal count after reset selects digit 0 (digit_en_o = 1).
- Button latency: a pad edge causes a state change 2 (sync) + DEBOUNCE_CYCLES + 1 cycles later.
- Tick to count update: 1 cycle. Count to seg_o: at most 1 cycle after the next digit select.
- running_o and expired_o are registered from the FSM state and are valid in the cycle after the transition.
- Reset asserted mid-count returns all state to reset values asynchronously. There is no pending tick or press after release.

## Structure
- Package seg_timer_pkg holds:
  - the FSM state encoding;
  - the BCD→7-segment decode function, with blank output for values above 9;
  - a clog2 helper for counter widths.
- Sub-module seg_debounce (synchroniser + stability counter + edge pulse), instantiated once per button.
- The BCD counter chain and the scan mux stay inline.

## Test plan
All scenarios use simulation parameters CLK_HZ=1000, TICK_HZ=100 (tick every 10 cycles), REFRESH_HZ=250 (4-cycle dwell), DEBOUNCE_CYCLES=4, NUM_DIGITS=4.
- Reset then idle 40 cycles → digit_en_o cycles 1,2,4,8 every 4 cycles. seg_o=0x3F (digit "0") on every digit; bit 7 is set only while digit_en_o=4.
- Up: start, run 1000 cycles → count=0100, running_o=1. Start again → PAUSE; the count holds for 200 cycles.
- Preset 9998 in up mode, run 30 cycles → 9999 then 0000; running_o stays 1.
- Down: load_value=0003, clear, start → after 30 cycles count=0000, expired_o=1, FSM=EXPIRED. Further start presses are ignored; clear drops expired_o.
- Bouncing start (toggle every 2 cycles for 12 cycles, then hold high) → exactly one RUN transition. A 3-cycle glitch → no transition.
- Clear and start pulses in the same cycle → FSM=IDLE. Reset asserted mid-RUN → all outputs 0 immediately.
